// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore FSM sequencing multiply/add/count enables.
// Ports: clk, reset, start, mode, abort, count -> enables, busy, done, error, state.
module datapath_sequencer #(
  parameter int unsigned MULT_CYCLES  = 4,
  parameter int unsigned SUM_CYCLES   = 2,
  parameter logic [3:0]  COUNT_TARGET = 4'd9,
  parameter int unsigned TIMEOUT      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic [3:0] count,
  output logic       multien,
  output logic       sumen,
  output logic       Consten,
  output logic       counten,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  localparam int unsigned PMAX =
    (MULT_CYCLES > SUM_CYCLES) ? MULT_CYCLES : SUM_CYCLES;
  localparam int unsigned PW = $clog2(PMAX + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] MULT_LAST = PW'(MULT_CYCLES - 1);
  localparam logic [PW-1:0] SUM_LAST  = PW'(SUM_CYCLES - 1);
  localparam logic [PW-1:0] PH_MAX    = PW'(PMAX);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_SUM   = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic          err_q, err_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          entering;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      err_q   <= 1'b0;
      phase_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    // abort wins over everything outside IDLE
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            mode_d  = mode;
            err_d   = 1'b0;
            state_d = (mode == 2'b00 || mode == 2'b11)
                      ? S_MULT : S_SUM;
          end
        end
        S_MULT: begin
          if (phase_q == MULT_LAST)
            state_d = (mode_q == 2'b11) ? S_SUM : S_COUNT;
        end
        S_SUM: begin
          if (phase_q == SUM_LAST)
            state_d = S_COUNT;
        end
        S_COUNT: begin
          if (count == COUNT_TARGET) begin
            state_d = S_DONE;
          end else if (wdog_q == WD_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    entering = (state_d != state_q);

    // phase counter only runs in MULT/SUM; saturates
    phase_d = '0;
    if (!entering && (state_q == S_MULT || state_q == S_SUM))
      phase_d = (phase_q == PH_MAX) ? phase_q : phase_q + PW'(1);

    // watchdog only runs in COUNT; saturates
    wdog_d = '0;
    if (!entering && state_q == S_COUNT)
      wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WW'(1);
  end

  assign multien = (state_q == S_MULT);
  assign sumen   = (state_q == S_SUM);
  assign Consten = (state_q == S_SUM) && (mode_q == 2'b10);
  assign counten = (state_q == S_COUNT);
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign error   = err_q;
  assign state   = state_q;

endmodule
